// File: rtl/pam_chunk_search_pkg.sv
// Shared constants and types for the PAMChunkSearch AXI4-Lite register slice.
package pam_chunk_search_pkg;

    localparam int NUM_REGS = 4;

    // Register indices as seen by the search core (word offset / 4).
    localparam int REG_CTRL    = 0;
    localparam int REG_PATTERN = 1;
    localparam int REG_BASE    = 2;
    localparam int REG_LEN     = 3;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/pam_chunk_search_strb_merge.sv
// Byte-lane merge: lanes with a strobe bit set take the new word, others keep the old one.
module pam_chunk_search_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_word,
    input  logic [DATA_WIDTH-1:0]   new_word,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged_word
);

    // Start from the current register value and overlay each strobed byte.
    always_comb begin
        merged_word = old_word;
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (strb[b]) begin
                merged_word[8*b +: 8] = new_word[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/pam_chunk_search_axil_regs.sv
// AXI4-Lite slave holding the four PAMChunkSearch control registers.
// One outstanding write and one outstanding read; all outputs registered.
module pam_chunk_search_axil_regs
    import pam_chunk_search_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                    reg_wr
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(NUM_REGS);

    // Write path
    w_state_t                      w_state;
    logic                          aw_full;
    logic                          w_full;
    logic [IDX_W-1:0]              aw_idx;
    logic [DW-1:0]                 w_data;
    logic [STRB_W-1:0]             w_strb;
    logic                          aw_ready_q;
    logic                          w_ready_q;
    logic                          b_valid_q;
    logic [NUM_REGS-1:0]           reg_wr_q;
    logic [NUM_REGS-1:0][DW-1:0]   regs;
    logic [DW-1:0]                 merged_word;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          commit;

    // Read path
    r_state_t                      r_state;
    logic                          ar_ready_q;
    logic                          r_valid_q;
    logic [DW-1:0]                 r_data_q;
    logic                          ar_hs;

    // Protection bits and the byte offset within a word carry no meaning here.
    logic                          unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_hs  = S_AXI_AWVALID && aw_ready_q;
    assign w_hs   = S_AXI_WVALID && w_ready_q;
    assign ar_hs  = S_AXI_ARVALID && ar_ready_q;
    assign commit = aw_full && w_full;

    pam_chunk_search_strb_merge #(
        .DATA_WIDTH (DW)
    ) u_strb_merge (
        .old_word    (regs[aw_idx]),
        .new_word    (w_data),
        .strb        (w_strb),
        .merged_word (merged_word)
    );

    // Write FSM: collect AW and W in any order, commit one edge after both are held,
    // then hold the B response until the master takes it.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state    <= W_IDLE;
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_idx     <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            reg_wr_q   <= '0;
            regs       <= '0;
        end else begin
            reg_wr_q <= '0;
            if (commit) begin
                regs[aw_idx]     <= merged_word;
                reg_wr_q[aw_idx] <= 1'b1;
                aw_full          <= 1'b0;
                w_full           <= 1'b0;
                aw_ready_q       <= 1'b0;
                w_ready_q        <= 1'b0;
                b_valid_q        <= 1'b1;
                w_state          <= W_RESP;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (aw_hs) begin
                            aw_idx  <= S_AXI_AWADDR[IDX_W+1:2];
                            aw_full <= 1'b1;
                        end
                        if (w_hs) begin
                            w_data <= S_AXI_WDATA;
                            w_strb <= S_AXI_WSTRB;
                            w_full <= 1'b1;
                        end
                        aw_ready_q <= !aw_hs;
                        w_ready_q  <= !w_hs;
                        if (aw_hs) begin
                            w_state <= W_HAVE_AW;
                        end else if (w_hs) begin
                            w_state <= W_HAVE_W;
                        end
                    end
                    W_HAVE_AW: begin
                        if (w_hs) begin
                            w_data    <= S_AXI_WDATA;
                            w_strb    <= S_AXI_WSTRB;
                            w_full    <= 1'b1;
                            w_ready_q <= 1'b0;
                        end
                    end
                    W_HAVE_W: begin
                        if (aw_hs) begin
                            aw_idx     <= S_AXI_AWADDR[IDX_W+1:2];
                            aw_full    <= 1'b1;
                            aw_ready_q <= 1'b0;
                        end
                    end
                    W_RESP: begin
                        if (S_AXI_BREADY) begin
                            b_valid_q  <= 1'b0;
                            aw_ready_q <= 1'b1;
                            w_ready_q  <= 1'b1;
                            w_state    <= W_IDLE;
                        end
                    end
                    default: begin
                        w_state <= W_IDLE;
                    end
                endcase
            end
        end
    end

    // Read FSM: capture the addressed register on the AR handshake and hold it
    // stable until the R handshake; a same-edge commit is not yet visible.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_data_q   <= regs[S_AXI_ARADDR[IDX_W+1:2]];
                        r_valid_q  <= 1'b1;
                        ar_ready_q <= 1'b0;
                        r_state    <= R_RESP;
                    end else begin
                        ar_ready_q <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                        r_state    <= R_IDLE;
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = OKAY;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = OKAY;
    assign reg_q         = regs;
    assign reg_wr        = reg_wr_q;

endmodule

// File: tb/tb_pam_chunk_search_axil_regs.sv
// Bench for the PAMChunkSearch AXI4-Lite register slice: directed scenarios followed by
// randomized traffic, checked against a cycle-level model and a read-data scoreboard.
`timescale 1ns/1ps
module tb_pam_chunk_search_axil_regs;
    import pam_chunk_search_pkg::*;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b1;
    logic [3:0]    S_AXI_AWADDR = '0;
    logic [2:0]    S_AXI_AWPROT = '0;
    logic          S_AXI_AWVALID = 1'b0;
    logic          S_AXI_AWREADY;
    logic [31:0]   S_AXI_WDATA = '0;
    logic [3:0]    S_AXI_WSTRB = '0;
    logic          S_AXI_WVALID = 1'b0;
    logic          S_AXI_WREADY;
    logic [1:0]    S_AXI_BRESP;
    logic          S_AXI_BVALID;
    logic          S_AXI_BREADY = 1'b1;
    logic [3:0]    S_AXI_ARADDR = '0;
    logic [2:0]    S_AXI_ARPROT = '0;
    logic          S_AXI_ARVALID = 1'b0;
    logic          S_AXI_ARREADY;
    logic [31:0]   S_AXI_RDATA;
    logic [1:0]    S_AXI_RRESP;
    logic          S_AXI_RVALID;
    logic          S_AXI_RREADY = 1'b1;
    logic [127:0]  reg_q;
    logic [3:0]    reg_wr;

    pam_chunk_search_axil_regs #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_q         (reg_q),
        .reg_wr        (reg_wr)
    );

    // 100 MHz clock.
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: the register file plus what the slave currently holds.
    logic [31:0] m_regs [4];
    logic        m_aw_held, m_w_held, m_b_pend, m_r_pend, m_rdy_en;
    logic [1:0]  m_aw_idx;
    logic [31:0] m_w_data;
    logic [3:0]  m_w_strb;
    logic [3:0]  m_wr_now;
    logic [31:0] exp_r_q [$];

    logic force_b_low = 1'b0;
    logic force_r_low = 1'b0;
    logic rand_rdy = 1'b0;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) mask = mask | (32'hFF << (8 * b));
        end
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_aw_held = 0; m_w_held = 0; m_b_pend = 0; m_r_pend = 0; m_rdy_en = 0;
        m_aw_idx = '0; m_w_data = '0; m_w_strb = '0; m_wr_now = '0;
        exp_r_q.delete();
    endtask

    // Monitor and model: compare the DUT against the model every cycle, then advance
    // the model by the handshakes that the coming edge will perform.
    initial begin : monitor
        logic aw_e, w_e, ar_e;
        model_reset();
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                checkOutput("reset_ctrl", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY,
                            S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, reg_wr, S_AXI_RDATA}, '0);
                checkOutput("reset_regs", reg_q, '0);
                model_reset();
            end else begin
                aw_e = m_rdy_en && !m_b_pend && !m_aw_held;
                w_e  = m_rdy_en && !m_b_pend && !m_w_held;
                ar_e = m_rdy_en && !m_r_pend;
                checkOutput("handshake_flags", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID},
                            {aw_e, w_e, m_b_pend, ar_e, m_r_pend});
                checkOutput("reg_q", reg_q, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
                checkOutput("reg_wr", reg_wr, m_wr_now);
                if (S_AXI_BVALID) checkOutput("bresp", S_AXI_BRESP, OKAY);
                if (S_AXI_RVALID) begin
                    if (exp_r_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL rdata_unexpected actual=%0h required=no response", S_AXI_RDATA);
                    end else begin
                        checkOutput("rdata", {S_AXI_RRESP, S_AXI_RDATA}, {OKAY, exp_r_q[0]});
                        if (S_AXI_RREADY) void'(exp_r_q.pop_front());
                    end
                end
                // Read capture sees the registers before any commit on the same edge.
                if (m_r_pend) begin
                    if (S_AXI_RREADY) m_r_pend = 0;
                end else if (ar_e && S_AXI_ARVALID) begin
                    exp_r_q.push_back(m_regs[S_AXI_ARADDR[3:2]]);
                    m_r_pend = 1;
                end
                m_wr_now = '0;
                if (m_aw_held && m_w_held) begin
                    m_regs[m_aw_idx]   = apply_strb(m_regs[m_aw_idx], m_w_data, m_w_strb);
                    m_wr_now[m_aw_idx] = 1'b1;
                    m_aw_held = 0;
                    m_w_held  = 0;
                    m_b_pend  = 1;
                end else begin
                    if (m_b_pend && S_AXI_BREADY) m_b_pend = 0;
                    if (aw_e && S_AXI_AWVALID) begin
                        m_aw_held = 1;
                        m_aw_idx  = S_AXI_AWADDR[3:2];
                    end
                    if (w_e && S_AXI_WVALID) begin
                        m_w_held = 1;
                        m_w_data = S_AXI_WDATA;
                        m_w_strb = S_AXI_WSTRB;
                    end
                end
                m_rdy_en = 1;
            end
        end
    end

    // Response-channel ready driver: held high, forced low, or randomized.
    initial begin : ready_driver
        forever begin
            @(posedge ACLK);
            #1;
            S_AXI_BREADY = !force_b_low && (!rand_rdy || ($urandom_range(0, 1) == 1));
            S_AXI_RREADY = !force_r_low && (!rand_rdy || ($urandom_range(0, 1) == 1));
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic wait_accept(input string name, input int which);
        int  n;
        logic seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge ACLK);
            case (which)
                0:       seen = S_AXI_AWREADY;
                1:       seen = S_AXI_WREADY;
                default: seen = S_AXI_ARREADY;
            endcase
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout actual=no handshake required=handshake within 200 cycles", name);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_aw(input logic [3:0] addr, input int dly);
        cycles(dly);
        S_AXI_AWADDR  = addr;
        S_AXI_AWPROT  = 3'($urandom_range(0, 7));
        S_AXI_AWVALID = 1'b1;
        wait_accept("aw", 0);
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly);
        cycles(dly);
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_WVALID = 1'b1;
        wait_accept("w", 1);
        S_AXI_WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] addr, input int dly);
        cycles(dly);
        S_AXI_ARADDR  = addr;
        S_AXI_ARPROT  = 3'($urandom_range(0, 7));
        S_AXI_ARVALID = 1'b1;
        wait_accept("ar", 2);
        S_AXI_ARVALID = 1'b0;
    endtask

    // One write and/or one read issued concurrently; lead > 0 means W goes lead cycles before AW.
    task automatic applyStimulus(input logic do_wr, input logic [3:0] waddr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input int lead,
                                 input logic do_rd, input logic [3:0] raddr, input int rdly);
        fork
            begin if (do_wr) send_aw(waddr, (lead > 0) ? lead : 0); end
            begin if (do_wr) send_w(wdata, wstrb, (lead < 0) ? -lead : 0); end
            begin if (do_rd) send_ar(raddr, rdly); end
        join
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog actual=still running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: directed scenarios, reset mid-transaction, then random traffic.
    initial begin : stimulus
        int wait_n;
        #1 ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;

        for (int i = 0; i < 4; i++) applyStimulus(1, 4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 4'h0, 32'h0, 4'h0, 0, 1, 4'(4 * i), 0);
        cycles(3);

        applyStimulus(1, 4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 4'h0, 0);
        cycles(1);
        checkOutput("deadbeef_reg_base", reg_q[REG_BASE*32 +: 32], 32'hDEADBEEF);
        cycles(2);

        applyStimulus(1, 4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 4'h0, 0);
        applyStimulus(1, 4'h5, 32'h00000000, 4'b0101, -1, 0, 4'h0, 0);
        cycles(1);
        checkOutput("strb_merge_reg_pattern", reg_q[REG_PATTERN*32 +: 32], 32'hFF00FF00);
        applyStimulus(0, 4'h0, 32'h0, 4'h0, 0, 1, 4'h4, 0);
        cycles(3);

        force_b_low = 1'b1;
        applyStimulus(1, 4'h0, 32'hA5A5_0001, 4'hF, 0, 1, 4'h0, 1);
        cycles(10);
        force_b_low = 1'b0;
        cycles(3);

        force_r_low = 1'b1;
        applyStimulus(0, 4'h0, 32'h0, 4'h0, 0, 1, 4'hC, 0);
        applyStimulus(1, 4'hE, 32'h1234_5678, 4'hF, 0, 0, 4'h0, 0);
        cycles(5);
        force_r_low = 1'b0;
        cycles(3);

        force_r_low = 1'b1;
        applyStimulus(1, 4'h8, 32'h0, 4'h0, 0, 0, 4'h0, 0);
        cycles(3);
        fork
            send_aw(4'h8, 0);
            send_ar(4'h4, 0);
        join
        cycles(2);
        @(posedge ACLK);
        #3 ARESETN = 1'b0;
        force_r_low = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(0, 4'h0, 32'h0, 4'h0, 0, 1, 4'(4 * i + 1), 0);
        applyStimulus(1, 4'h3, 32'hCAFEF00D, 4'hF, 0, 0, 4'h0, 0);
        applyStimulus(0, 4'h0, 32'h0, 4'h0, 0, 1, 4'h2, 0);
        cycles(3);

        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                          4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3,
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            cycles($urandom_range(0, 2));
        end
        rand_rdy = 1'b0;

        wait_n = 0;
        while ((S_AXI_BVALID || S_AXI_RVALID || exp_r_q.size() != 0) && wait_n < 50) begin
            cycles(1);
            wait_n++;
        end
        checkOutput("read_queue_drained", 128'(exp_r_q.size()), '0);
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pam_chunk_search_axil_regs.md
# pam_chunk_search_axil_regs

AXI4-Lite slave register file for the PAMChunkSearch IP and the responder for the `S00_AXI` master. It exposes four 32-bit read/write control registers at word offsets 0x0, 0x4, 0x8 and 0xC. Register contents and per-register write pulses are driven to the search core. The block accepts one outstanding write and one outstanding read, with full backpressure on the response channels.

## Interface
Parameters:
- `C_S_AXI_DATA_WIDTH`, 32: data width; only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, 4: address width; bits [3:2] select the register, bits [1:0] are ignored.

Ports:
- `ACLK` in 1: the single clock.
- `ARESETN` in 1: asynchronous active-low reset.
- `S_AXI_AWADDR` in 4, `S_AXI_AWPROT` in 3 (ignored), `S_AXI_AWVALID` in 1, `S_AXI_AWREADY` out 1.
- `S_AXI_WDATA` in 32, `S_AXI_WSTRB` in 4, `S_AXI_WVALID` in 1, `S_AXI_WREADY` out 1.
- `S_AXI_BRESP` out 2, `S_AXI_BVALID` out 1, `S_AXI_BREADY` in 1.
- `S_AXI_ARADDR` in 4, `S_AXI_ARPROT` in 3 (ignored), `S_AXI_ARVALID` in 1, `S_AXI_ARREADY` out 1.
- `S_AXI_RDATA` out 32, `S_AXI_RRESP` out 2, `S_AXI_RVALID` out 1, `S_AXI_RREADY` in 1.
- `reg_q` out 4x32: register contents; register 0 occupies [31:0].
- `reg_wr` out 4: one-cycle pulse per register on a committed write.

## Operation
Write path state machine:
- States are `W_IDLE`, `W_HAVE_AW`, `W_HAVE_W` and `W_RESP`.
- AW and W are accepted independently, in either order or in the same cycle. Each is latched on its handshake.
- `AWREADY` is high only in `W_IDLE` and `W_HAVE_W`. `WREADY` is high only in `W_IDLE` and `W_HAVE_AW`.
- When both AW and W are held, the write commits on that clock edge:
  - for each byte lane with `WSTRB[b]`=1, `reg[idx][8b+7:8b]` takes the new data;
  - `reg_wr[idx]` pulses for one cycle, even when `WSTRB` is 0;
  - the state moves to `W_RESP`.
- In `W_RESP`, `BVALID` is 1 and `BRESP`=OKAY. The state returns to `W_IDLE` on the `BVALID`&`BREADY` handshake.

Read path state machine:
- States are `R_IDLE` and `R_RESP`.
- `ARREADY` is high only in `R_IDLE`.
- On AR handshake, `RDATA` is captured as `reg[ARADDR[3:2]]` and the state moves to `R_RESP`. `RVALID` is 1 and `RRESP`=OKAY.
- `RDATA` stays stable until the `RVALID`&`RREADY` handshake, which returns the state to `R_IDLE`.

Collisions and boundary conditions:
- A read and a write commit to the same register on the same edge: the read returns the pre-write value.
- Write and read paths are fully independent. Neither blocks the other.
- The address decode uses only bits [3:2], so every address aliases into the four registers. There is no SLVERR.
- A write whose response is not yet taken blocks further AW and W acceptance. There is no overflow path.

Reset:
- `ARESETN` low, whether asserted mid-transaction or not, forces both FSMs to idle. Pending AW, W and AR are discarded.
- All registers and `reg_q` clear to 0.
- `BVALID`, `RVALID`, `RDATA`, `BRESP`, `RRESP` and `reg_wr` are 0.
- `AWREADY`, `WREADY` and `ARREADY` are 0 during reset and 1 from the first `ACLK` edge after deassertion.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Write latency:
  - AW and W in the same cycle: accepted at edge N, commit and `reg_q` update at edge N+1, `BVALID` high after edge N+1.
  - AW and W in separate cycles: the commit occurs one edge after the later handshake.
- Read latency: AR handshake at edge N gives `RVALID` and `RDATA` valid after edge N. The next `ARREADY` is high in the cycle after the R handshake.
- Throughput with `BREADY` and `RREADY` tied high:
  - one write every 3 cycles;
  - one read every 2 cycles.
- `reg_q` reflects a committed write on the same edge that raises `BVALID`. `reg_wr` is high for exactly that cycle.

## Structure
- Package `pam_chunk_search_pkg` holds:
  - `NUM_REGS`=4;
  - the register index constants `REG_CTRL`=0, `REG_PATTERN`=1, `REG_BASE`=2, `REG_LEN`=3;
  - the `axi_resp_t` enum with OKAY=2'b00;
  - the write and read FSM state enums.
- One sub-module, `pam_chunk_search_strb_merge`, applies `WSTRB` to produce `old_word` merged with `new_word`. It is combinational and instantiated once.
- The FSMs and the register array stay in the top module.

## Test plan
- Sequential writes of 0x1, 0x2, 0x3, 0x4 to 0x0 through 0xC, then reads -> read data is 0x1, 0x2, 0x3, 0x4, all OKAY. `reg_wr` pulses once per register in order.
- W issued 3 cycles before AW to 0x8 with data 0xDEADBEEF -> `WREADY` low until AW arrives. `reg_q[2]`=0xDEADBEEF and `BVALID` asserts one cycle after the AW handshake.
- Write 0xFFFFFFFF to 0x4, then write 0x00000000 with `WSTRB`=4'b0101 -> a read of 0x4 returns 0xFF00FF00.
- `BREADY` held low for 10 cycles after a write -> `BVALID` holds, and `AWREADY` and `WREADY` stay low. A concurrent read of 0x0 completes normally.
- `RREADY` low for 5 cycles after a read of 0xC -> `RDATA` stays stable. A write to 0xC committing during that window does not change `RDATA`.
- `ARESETN` pulsed low while `W_HAVE_AW` and `R_RESP` are pending -> all registers read back 0. `BVALID`=`RVALID`=0, and a subsequent write/read pair succeeds.
